// File: rtl/uart_rx_fifo_driver.sv
// uart_rx_fifo_driver
//   Single-clock UART receiver feeding a small FIFO, with a CPU-side
//   pop-on-read port that returns a 16-bit status+data word.
//
// Ports
//   iFpgaClock   in   1       sole clock, all logic on posedge
//   iCpuReset    in   1       synchronous active-high reset
//   iUartCtrl    in   1       address decode select
//   iIoRead      in   1       IO read strobe; pop when iUartCtrl && iIoRead
//   iUartFromPc  in   1       asynchronous RX line, idle high
//   oUartData    out  16      {valid, overrun, ferr, perr, 4'b0, data[7:0]}
//   oRxNotEmpty  out  1       FIFO holds at least one frame
//   oRxCount     out  CW      FIFO occupancy, CW = $clog2(FIFO_DEPTH)+1
module uart_rx_fifo_driver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int UART_BPS   = 128000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          iFpgaClock,
  input  logic                          iCpuReset,
  input  logic                          iUartCtrl,
  input  logic                          iIoRead,
  input  logic                          iUartFromPc,
  output logic [15:0]                   oUartData,
  output logic                          oRxNotEmpty,
  output logic [$clog2(FIFO_DEPTH):0]   oRxCount
);

  localparam int CLKS_PER_BIT = CLK_FREQ / UART_BPS;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FCNT_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------
  // RX line synchroniser; rx_prev_reg gives the edge detector its
  // previous sample so a start needs an observed high->low transition.
  // ---------------------------------------------------------------
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

  always_ff @(posedge iFpgaClock) begin
    if (iCpuReset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= iUartFromPc;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // ---------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------
  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 perr_reg, perr_next;
  logic                 push;
  logic                 push_ferr;

  always_ff @(posedge iFpgaClock) begin
    if (iCpuReset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      perr_reg  <= perr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    perr_next  = perr_reg;
    push       = 1'b0;
    push_ferr  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Only a real falling edge starts a frame, so a line stuck low
        // after a bad stop bit cannot retrigger reception.
        if (rx_prev_reg && !rx_sync_reg) begin
          state_next = S_START;
          cnt_next   = '0;
        end
      end
      S_START: begin
        if (cnt_reg == HALF_CNT) begin
          cnt_next = '0;
          if (rx_sync_reg) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
            bit_next   = '0;
            perr_next  = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          // LSB first: shift in from the top so the first bit ends at bit 0.
          shift_next = {rx_sync_reg, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == LAST_BIT) begin
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          state_next = S_STOP;
          if (PARITY == 1) begin
            perr_next = ~(^{shift_reg, rx_sync_reg});
          end else begin
            perr_next = ^{shift_reg, rx_sync_reg};
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          state_next = S_IDLE;
          push       = 1'b1;
          push_ferr  = ~rx_sync_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Zero-extend the received data to a byte.
  logic [7:0] data8;
  always_comb begin
    data8                  = '0;
    data8[DATA_BITS-1:0]   = shift_reg;
  end

  // ---------------------------------------------------------------
  // FIFO: entry = {perr, ferr, data[7:0]}
  // ---------------------------------------------------------------
  logic [9:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [FCNT_W-1:0] count_reg, count_next;
  logic              overrun_reg, overrun_next;
  logic              not_empty_reg;
  logic [15:0]       data_out_reg;
  logic              rd, pop, full, do_push;

  assign rd      = iUartCtrl && iIoRead;
  assign pop     = rd && (count_reg != '0);
  assign full    = (count_reg == FULL_CNT);
  // When full, a pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || pop);

  always_comb begin
    count_next   = count_reg + FCNT_W'(do_push) - FCNT_W'(pop);
    overrun_next = rd ? 1'b0 : overrun_reg;
    if (push && !do_push) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge iFpgaClock) begin
    if (do_push && !iCpuReset) begin
      mem[wr_ptr_reg] <= {perr_reg, push_ferr, data8};
    end
  end

  always_ff @(posedge iFpgaClock) begin
    if (iCpuReset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overrun_reg   <= 1'b0;
      not_empty_reg <= 1'b0;
      data_out_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd) begin
        if (count_reg != '0) begin
          data_out_reg <= {1'b1, overrun_reg, mem[rd_ptr_reg][8],
                           mem[rd_ptr_reg][9], 4'b0000, mem[rd_ptr_reg][7:0]};
          rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        end else begin
          data_out_reg <= {1'b0, overrun_reg, 14'b0};
        end
      end
      count_reg     <= count_next;
      overrun_reg   <= overrun_next;
      not_empty_reg <= (count_next != '0);
    end
  end

  assign oUartData   = data_out_reg;
  assign oRxCount    = count_reg;
  assign oRxNotEmpty = not_empty_reg;

endmodule

// File: tb/tb_uart_rx_fifo_driver.sv
// Testbench for uart_rx_fifo_driver: three instances with different
// data width / parity / depth, directed scenarios plus randomized frames
// checked against a queue-style behavioural model.
module tb_uart_rx_fifo_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst;
  logic       io_read;
  logic [2:0] ctrl;
  logic [2:0] rx;

  logic [15:0] data0, data1, data2;
  logic        ne0, ne1, ne2;
  logic [2:0]  cnt0;
  logic [4:0]  cnt1;
  logic [2:0]  cnt2;

  uart_rx_fifo_driver #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
    .iFpgaClock(clk), .iCpuReset(srst), .iUartCtrl(ctrl[0]), .iIoRead(io_read),
    .iUartFromPc(rx[0]), .oUartData(data0), .oRxNotEmpty(ne0), .oRxCount(cnt0));
  uart_rx_fifo_driver #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)) dut1 (
    .iFpgaClock(clk), .iCpuReset(srst), .iUartCtrl(ctrl[1]), .iIoRead(io_read),
    .iUartFromPc(rx[1]), .oUartData(data1), .oRxNotEmpty(ne1), .oRxCount(cnt1));
  uart_rx_fifo_driver #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(6), .PARITY(1), .FIFO_DEPTH(4)) dut2 (
    .iFpgaClock(clk), .iCpuReset(srst), .iUartCtrl(ctrl[2]), .iIoRead(io_read),
    .iUartFromPc(rx[2]), .oUartData(data2), .oRxNotEmpty(ne2), .oRxCount(cnt2));

  int checks = 0;
  int errors = 0;

  int depth_p [3] = '{4, 16, 4};
  int nbits_p [3] = '{8, 8, 6};
  int par_p   [3] = '{0, 2, 1};

  // Model: ordered list of stored frames per instance, {perr, ferr, data}
  logic [9:0] mq   [3][16];
  int         mcnt [3];
  bit         mov  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] get_data(input int i);
    case (i)
      0: return data0;
      1: return data1;
      default: return data2;
    endcase
  endfunction

  function automatic int get_cnt(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic logic get_ne(input int i);
    case (i)
      0: return ne0;
      1: return ne1;
      default: return ne2;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      mov[i]  = 1'b0;
    end
  endtask

  task automatic drive_bit(input int i, input logic b);
    rx[i] = b;
    tick(16);
  endtask

  // Receiver's view of one frame, straight from the framing rules.
  task automatic model_frame(input int i, input logic [7:0] d, input logic pbit, input logic stop);
    int   ones;
    logic perr;
    ones = $countones(d) + int'(pbit);
    perr = 1'b0;
    if (par_p[i] == 1) perr = (ones % 2 == 0);
    if (par_p[i] == 2) perr = (ones % 2 == 1);
    if (mcnt[i] < depth_p[i]) begin
      mq[i][mcnt[i]] = {perr, ~stop, d};
      mcnt[i]++;
    end else begin
      mov[i] = 1'b1;
    end
  endtask

  // Sends start, data, optional parity and stop; leaves line at stop level.
  task automatic send_raw(input int i, input logic [7:0] din, input logic par_ok, input logic stop);
    logic [7:0] d;
    logic       pbit;
    d = din & 8'((1 << nbits_p[i]) - 1);
    pbit = 1'b0;
    if (par_p[i] == 1) pbit = ($countones(d) % 2 == 0);
    if (par_p[i] == 2) pbit = ($countones(d) % 2 == 1);
    if (!par_ok) pbit = ~pbit;
    drive_bit(i, 1'b0);
    for (int b = 0; b < nbits_p[i]; b++) drive_bit(i, d[b]);
    if (par_p[i] != 0) drive_bit(i, pbit);
    drive_bit(i, stop);
    model_frame(i, d, (par_p[i] != 0) ? pbit : 1'b0, stop);
  endtask

  task automatic send_idle(input int i, input logic [7:0] d, input logic par_ok, input logic stop);
    send_raw(i, d, par_ok, stop);
    rx[i] = 1'b1;
    tick(8);
  endtask

  task automatic check_cnt(input int i, input string tag);
    check($sformatf("%s_cnt%0d", tag, i), get_cnt(i), mcnt[i]);
    check($sformatf("%s_ne%0d", tag, i), {31'b0, get_ne(i)}, {31'b0, (mcnt[i] != 0)});
  endtask

  task automatic do_read(input int i, output logic [15:0] obs);
    logic [15:0] exp;
    if (mcnt[i] > 0) begin
      exp = {1'b1, mov[i], mq[i][0][8], mq[i][0][9], 4'b0000, mq[i][0][7:0]};
      for (int j = 0; j < 15; j++) mq[i][j] = mq[i][j+1];
      mcnt[i]--;
    end else begin
      exp = {1'b0, mov[i], 14'b0};
    end
    mov[i] = 1'b0;
    ctrl[i] = 1'b1;
    io_read = 1'b1;
    tick(1);
    ctrl[i] = 1'b0;
    io_read = 1'b0;
    obs = get_data(i);
    check($sformatf("read%0d", i), {16'b0, obs}, {16'b0, exp});
    check_cnt(i, "after_read");
    $display("read inst=%0d data=%04h count=%0d", i, obs, get_cnt(i));
  endtask

  initial begin
    logic [15:0] obs;
    logic [7:0]  v;
    int          nfr, nrd;
    srst = 1'b1; io_read = 1'b0; ctrl = '0; rx = '1;
    clear_model();
    tick(3);
    srst = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_data%0d", i), {16'b0, get_data(i)}, 32'h0);
      check_cnt(i, "reset");
    end

    // 1: basic 8N1 byte
    send_idle(0, 8'hA5, 1'b1, 1'b1);
    check("t1_cnt_one", get_cnt(0), 1);
    check_cnt(0, "t1");
    do_read(0, obs);
    check("t1_data", {16'b0, obs}, 32'h80A5);
    check("t1_cnt_zero", get_cnt(0), 0);

    // 2: even parity, bad then good parity bit
    send_idle(1, 8'h03, 1'b0, 1'b1);
    do_read(1, obs);
    check("t2_perr", {16'b0, obs}, 32'h9003);
    send_idle(1, 8'h03, 1'b1, 1'b1);
    do_read(1, obs);
    check("t2_ok", {16'b0, obs}, 32'h8003);

    // 3: low stop bit, line held low; nothing restarts until it goes high
    send_raw(0, 8'h55, 1'b1, 1'b0);
    tick(200);
    check_cnt(0, "t3_low_hold");
    rx[0] = 1'b1;
    tick(32);
    send_idle(0, 8'h12, 1'b1, 1'b1);
    do_read(0, obs);
    check("t3_ferr", {16'b0, obs}, 32'hA055);
    do_read(0, obs);
    check("t3_next", {16'b0, obs}, 32'h8012);

    // 4: overflow a depth-4 FIFO
    for (int k = 1; k <= 5; k++) begin
      send_idle(0, 8'(k), 1'b1, 1'b1);
      check_cnt(0, "t4_fill");
    end
    check("t4_full", get_cnt(0), 4);
    do_read(0, obs);
    check("t4_ovr", {16'b0, obs}, 32'hC001);
    do_read(0, obs);
    check("t4_second", {16'b0, obs}, 32'h8002);
    do_read(0, obs);
    do_read(0, obs);

    // 6a: read while empty
    do_read(0, obs);
    check("t6_empty", {16'b0, obs}, 32'h0000);

    // 5: short low glitch is a false start
    rx[0] = 1'b0;
    tick(4);
    rx[0] = 1'b1;
    tick(200);
    check_cnt(0, "t5_glitch");
    check("t5_cnt", get_cnt(0), 0);

    // 6b: reset in the middle of a frame
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    rx[0] = 1'b1;
    srst = 1'b1;
    tick(1);
    srst = 1'b0;
    clear_model();
    check("t6_rst_data", {16'b0, data0}, 32'h0);
    check_cnt(0, "t6_rst");
    tick(64);
    check_cnt(0, "t6_quiet");
    send_idle(0, 8'h31, 1'b1, 1'b1);
    do_read(0, obs);
    check("t6_after", {16'b0, obs}, 32'h8031);

    // Randomized bursts on the parity-enabled instances
    for (int i = 1; i <= 2; i++) begin
      for (int it = 0; it < 20; it++) begin
        nfr = $urandom_range(0, 5);
        for (int f = 0; f < nfr; f++) begin
          v = 8'($urandom);
          send_idle(i, v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
          check_cnt(i, "rand_push");
        end
        nrd = $urandom_range(1, nfr + 1);
        for (int r = 0; r < nrd; r++) do_read(i, obs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #5_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
